latch_top: RTL and testbench

Reference block with three functionally identical 4-bit level-sensitive (transparent-high) latches on one clock and one data bus. Each latch is a separately coded submodule in one of the team's three HDL flavours: SystemVerilog, Verilog-2001 and VHDL. The block is the team's teaching and lint-reference case for inferred latches. It also serves as a cross-language equivalence check, and it is not for use in production datapaths.

---
 rtl/latch_top.sv | 137 +++++++++++++
 tb/tb_latch_top.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/latch_top.sv
// ---------------------------------------------------------------------------
// latch_top
//
// Reference block for inferred latches. It holds three functionally identical
// transparent-high latches with asynchronous active-low reset. They are coded
// in three HDL idioms and share one enable and one data bus:
//   latch_sv  : SystemVerilog always_latch
//   latch_v   : Verilog-2001 always @* with an incomplete if
//   latch_vhd : mirrors the VHDL entity (a process with an explicit
//               sensitivity list and an incomplete if), written in SV so the
//               block builds in a single-language flow
// This block is for teaching and equivalence checking only. Do not use it in
// production datapaths.
//
// Configuration macro: LATCH_MISMATCH_CHECK_EN
//   defined   : a comparator drives `mismatch`, and in simulation an immediate
//               assertion reports any disagreement while out of reset
//   undefined : `mismatch` is tied to 0 and the port is kept
//
// Ports:
//   clk       in   latch enable (transparent while 1, opaque while 0)
//   reset_n   in   asynchronous active-low clear of all latch outputs
//   d_in      in   [WIDTH] shared data
//   q_sv      out  [WIDTH] always_latch output
//   q_v       out  [WIDTH] Verilog always @* output
//   q_vhd     out  [WIDTH] VHDL-style process output
//   mismatch  out  high when any two latch outputs differ
// ---------------------------------------------------------------------------

module latch_sv #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: each latch block writes exactly one variable and never reads it, so
  // blocking and non-blocking give identical results. Blocking keeps the
  // level-sensitive block in the same evaluation style as combinational logic.
  always_latch begin
    if (!reset_n) q = '0;
    else if (clk) q = d;
  end

endmodule

module latch_v #(
  parameter integer WIDTH = 4
) (
  input  wire             clk,
  input  wire             reset_n,
  input  wire [WIDTH-1:0] d,
  output reg  [WIDTH-1:0] q
);

  // NOTE: the missing final else is deliberate. With no assignment while
  // clk = 0, the tool has to infer a storage element that holds q.
  always @* begin
    if (!reset_n) q = {WIDTH{1'b0}};
    else if (clk) q = d;
  end

endmodule

module latch_vhd #(
  parameter integer WIDTH = 4
) (
  input  wire             clk,
  input  wire             reset_n,
  input  wire [WIDTH-1:0] d,
  output reg  [WIDTH-1:0] q
);

  // Explicit sensitivity list, the same as the VHDL process(clk, reset_n, d).
  always @(clk, reset_n, d) begin
    if (reset_n == 1'b0) q = {WIDTH{1'b0}};
    else if (clk == 1'b1) q = d;
  end

endmodule

module latch_top #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_sv,
  output logic [WIDTH-1:0] q_v,
  output logic [WIDTH-1:0] q_vhd,
  output logic             mismatch
);

  // The three latches are separate instances with no shared logic. Any
  // divergence therefore comes from a difference in coding idiom.
  latch_sv #(.WIDTH(WIDTH)) u_sv (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (d_in),
    .q       (q_sv)
  );

  latch_v #(.WIDTH(WIDTH)) u_v (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (d_in),
    .q       (q_v)
  );

  latch_vhd #(.WIDTH(WIDTH)) u_vhd (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (d_in),
    .q       (q_vhd)
  );

`ifdef LATCH_MISMATCH_CHECK_EN
  // Two comparisons cover all three pairs. If sv == v and v == vhd,
  // then sv == vhd follows.
  assign mismatch = (q_sv != q_v) || (q_v != q_vhd);

`ifndef SYNTHESIS
  always_comb begin
    if (reset_n) begin
      assert (!mismatch)
        else $error("latch_top: latch outputs disagree sv=%h v=%h vhd=%h",
                    q_sv, q_v, q_vhd);
    end
  end
`endif
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_latch_top.sv
// ---------------------------------------------------------------------------
// tb_latch_top
//
// Directed bench for latch_top. Every stimulus step pushes the required latch
// value onto a scoreboard queue. One time unit later, check() pops that entry
// and compares all three latch outputs and mismatch against it.
// ---------------------------------------------------------------------------

module tb_latch_top;

  localparam int W = 4;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] d_in;
  logic [W-1:0] q_sv;
  logic [W-1:0] q_v;
  logic [W-1:0] q_vhd;
  logic         mismatch;

  latch_top #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .d_in     (d_in),
    .q_sv     (q_sv),
    .q_v      (q_v),
    .q_vhd    (q_vhd),
    .mismatch (mismatch)
  );

  typedef struct {
    string        tag;
    logic [W-1:0] q;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference latch state for the sweep, built from the sweep's own stimulus.
  logic [W-1:0] model_q;

  task automatic drive(input logic c, input logic r, input logic [W-1:0] d);
    clk     = c;
    reset_n = r;
    d_in    = d;
  endtask

  task automatic expect_q(input string tag, input logic [W-1:0] q);
    exp_t e;
    e.tag = tag;
    e.q   = q;
    sb.push_back(e);
  endtask

  // Waits one unit for the outputs to settle, then pops one expectation and
  // compares all four outputs against it.
  task automatic check();
    exp_t e;
    #1;
    vectors++;
    assert (sb.size() != 0) else begin
      miscompares++;
      $error("FAIL scoreboard_empty: got size %0d want >0", sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      vectors++;
      assert (q_sv === e.q) else begin
        miscompares++;
        $error("FAIL %s q_sv: got %h want %h", e.tag, q_sv, e.q);
      end
      vectors++;
      assert (q_v === e.q) else begin
        miscompares++;
        $error("FAIL %s q_v: got %h want %h", e.tag, q_v, e.q);
      end
      vectors++;
      assert (q_vhd === e.q) else begin
        miscompares++;
        $error("FAIL %s q_vhd: got %h want %h", e.tag, q_vhd, e.q);
      end
      vectors++;
      assert (mismatch === 1'b0) else begin
        miscompares++;
        $error("FAIL %s mismatch: got %b want 0", e.tag, mismatch);
      end
    end
  endtask

  // Applies one step and checks it, so stimulus and expectation stay together.
  task automatic step(input string tag, input logic c, input logic r,
                      input logic [W-1:0] d, input logic [W-1:0] q);
    drive(c, r, d);
    expect_q(tag, q);
    check();
  endtask

  initial begin
    int k;
    logic [W-1:0] v;
    logic c;

    // Reset while transparent: the clear has priority over clk = 1.
    step("reset",        1'b1, 1'b0, 4'hA, 4'h0);
    #4;

    // Release with clk = 1 takes d_in at once, then each value is tracked.
    step("release_high", 1'b1, 1'b1, 4'hA, 4'hA);
    #5;
    step("transp_3",     1'b1, 1'b1, 4'h3, 4'h3);
    #5;
    step("transp_7",     1'b1, 1'b1, 4'h7, 4'h7);
    #5;
    step("transp_c",     1'b1, 1'b1, 4'hC, 4'hC);
    #5;

    // Hold: capture 5 at the falling edge and ignore later d_in changes.
    step("pre_fall_5",   1'b1, 1'b1, 4'h5, 4'h5);
    #2;
    step("hold_fall",    1'b0, 1'b1, 4'h5, 4'h5);
    #5;
    step("hold_9",       1'b0, 1'b1, 4'h9, 4'h5);
    #5;
    step("hold_f",       1'b0, 1'b1, 4'hF, 4'h5);
    #5;
    step("rise_f",       1'b1, 1'b1, 4'hF, 4'hF);
    #5;

    // Asynchronous reset during hold. The outputs stay 0 after release until
    // clk rises again.
    step("pre_fall_5b",  1'b1, 1'b1, 4'h5, 4'h5);
    #2;
    step("hold_5b",      1'b0, 1'b1, 4'h5, 4'h5);
    #3;
    step("rst_mid_hold", 1'b0, 1'b0, 4'h5, 4'h0);
    #0;
    step("rst_release",  1'b0, 1'b1, 4'h5, 4'h0);
    #3;
    step("post_rst_d8",  1'b0, 1'b1, 4'h8, 4'h0);
    #3;
    step("post_rst_rise",1'b1, 1'b1, 4'h8, 4'h8);
    #3;

`ifndef LATCH_MISMATCH_CHECK_EN
    // Without the comparator, mismatch stays 0 even when q_v is forced to
    // disagree with the other two outputs.
    drive(1'b1, 1'b1, 4'h9);
    force dut.q_v = 4'h6;
    #1;
    vectors++;
    assert (mismatch === 1'b0) else begin
      miscompares++;
      $error("FAIL cfg_off_mismatch: got %b want 0", mismatch);
    end
    vectors++;
    assert (q_sv === 4'h9) else begin
      miscompares++;
      $error("FAIL cfg_off_q_sv: got %h want 9", q_sv);
    end
    release dut.q_v;
    #2;
    step("cfg_off_after", 1'b1, 1'b1, 4'hA, 4'hA);
    #2;
    step("cfg_off_d8",    1'b1, 1'b1, 4'h8, 4'h8);
    #2;
`endif

    // Close the latch on 8 before the sweep so the first sweep vector does not
    // coincide with a falling edge.
    step("pre_sweep_fall", 1'b0, 1'b1, 4'h8, 4'h8);
    #2;
    model_q = 4'h8;

    // Full sweep: 0..F then 0, one vector every 6 units. clk has a 20-unit
    // period and is high for t%20 in [3,12], so falls land at 13, 33, 53, ...
    // and no d_in change is closer than 1 unit to a fall.
    for (int t = 0; t < 102; t++) begin
      k = t / 6;
      v = (k >= 16) ? 4'h0 : W'(k);
      c = ((t % 20) >= 3) && ((t % 20) < 13);
      if (c) model_q = v;
      step($sformatf("sweep_t%0d", t), c, 1'b1, v, model_q);
    end

    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_leftover: got %0d want 0", sb.size());
    end
    vectors++;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
